// File: rtl/mips_pkg.sv
// Shared Mini MIPS definitions: sequencer state encoding, jump-class opcodes
// and the instruction-type classification used by the core.
package mips_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_FAULT  = 3'd5
    } seq_state_e;

    localparam logic [5:0] OP_JR  = 6'd1;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_JAL = 6'd3;

    typedef enum logic [1:0] {
        ITYPE_R    = 2'd0,
        ITYPE_I    = 2'd1,
        ITYPE_JUMP = 2'd2
    } instr_type_e;

    function automatic instr_type_e instr_type(input logic [5:0] opcode);
        instr_type_e t;
        case (opcode)
            6'd0:        t = ITYPE_R;
            OP_J, OP_JAL: t = ITYPE_JUMP;
            default:     t = ITYPE_I;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// 8-bit FETCH wait counter; terminal flags the last permitted no-ack cycle.
module fetch_timeout_ctr #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_r;

    // Wait-cycle count, saturating at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (en && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign terminal = (cnt_r == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/decode/exec/update sequencer owning the architectural PC.
// Strobes are decoded from the state register only.
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        exec_done,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        pc_commit,
    output logic        running,
    output logic        fault,
    output logic [31:0] retired
);

    seq_state_e  state_r;
    logic [31:0] pc_r;
    logic [31:0] ir_r;
    logic [31:0] retired_r;
    logic        fault_r;
    logic        halt_pend_r;
    logic        timeout_s;
    logic        active_s;

    assign active_s = (state_r != ST_IDLE) && (state_r != ST_FAULT);

    // Counter is only meaningful inside FETCH, so any other state holds it clear.
    fetch_timeout_ctr #(
        .LIMIT(IMEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_r != ST_FETCH),
        .en      ((state_r == ST_FETCH) && !imem_ack),
        .terminal(timeout_s)
    );

    // Main sequencing FSM with PC, IR, retire count and fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            pc_r      <= RESET_PC;
            ir_r      <= 32'd0;
            retired_r <= 32'd0;
            fault_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_r    <= imem_rdata;
                        state_r <= ST_DECODE;
                    end else if (timeout_s) begin
                        fault_r <= 1'b1;
                        state_r <= ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        state_r <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    pc_r      <= next_pc;
                    retired_r <= retired_r + 32'd1;
                    state_r   <= (halt_pend_r || halt_req) ? ST_IDLE : ST_FETCH;
                end
                ST_FAULT: begin
                    state_r <= ST_FAULT;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Halt request latch; an UPDATE consumes it together with any same-cycle request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_pend_r <= 1'b0;
        end else if (state_r == ST_UPDATE) begin
            halt_pend_r <= 1'b0;
        end else if (active_s && halt_req) begin
            halt_pend_r <= 1'b1;
        end else begin
            halt_pend_r <= halt_pend_r;
        end
    end

    assign imem_req  = (state_r == ST_FETCH);
    assign imem_addr = pc_r;
    assign ir        = ir_r;
    assign ir_valid  = (state_r == ST_DECODE);
    assign pc        = pc_r;
    assign pc_commit = (state_r == ST_UPDATE);
    assign running   = active_s;
    assign fault     = fault_r;
    assign retired   = retired_r;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multicycle instruction-sequencing controller for the Mini MIPS core. It owns the architectural PC register and fetches instructions from instruction memory over a req/ack handshake. It presents each fetched instruction to decode and waits for the datapath to finish execution. It then commits the next PC computed combinationally by `pc_increment` from the current PC, branch/zero and jump inputs. It sits between instruction memory and the decode/execute datapath; the rest of the core advances only on its state strobes.

## Interface
- `RESET_PC`, 32'd0: PC value loaded at reset (word address).
- `IMEM_TIMEOUT`, 16: FETCH cycles without ack before fault (range 1..255).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; leaves IDLE when high.
- `halt_req` in 1: request to stop after the current instruction commits.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_ack` in 1: fetch data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `ir` out 32: instruction register.
- `ir_valid` out 1: one-cycle pulse in DECODE.
- `exec_done` in 1: datapath finished EXEC.
- `next_pc` in 32: next PC from `pc_increment`.
- `pc` out 32: current PC, fed to `pc_increment.PC`.
- `pc_commit` out 1: pulse in UPDATE.
- `running` out 1: high in any state except IDLE/FAULT.
- `fault` out 1: sticky fetch-timeout flag.
- `retired` out 32: committed-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, FAULT (3-bit encoding).
- IDLE: all strobes low. Go to FETCH when `start`=1.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - If `imem_ack`=1: `ir`<=`imem_rdata`, go to DECODE.
  - Otherwise increment the wait counter. When the counter reaches `IMEM_TIMEOUT`, go to FAULT.
  - The wait counter clears on every FETCH entry.
- DECODE: `ir_valid`=1 for one cycle, then go to EXEC.
- EXEC: hold until `exec_done`=1. This includes `exec_done`=1 in the first EXEC cycle. Then go to UPDATE.
- UPDATE: `pc`<=`next_pc`, `pc_commit`=1, `retired`<=`retired`+1 (wraps modulo 2^32).
  - If a halt is pending: clear it and go to IDLE.
  - Otherwise go to FETCH.
- FAULT: `imem_req`=0, `fault`=1. Ignores `start`. Exits only on reset.
- Halt pending: a flag set when `halt_req`=1 in any state except IDLE/FAULT, cleared in UPDATE. If `halt_req` is asserted during the UPDATE cycle itself, that UPDATE honors it. The instruction already in flight always commits.
- `imem_ack` is ignored outside FETCH. `exec_done` is ignored outside EXEC.
- `start` while running has no effect. A `start` level held through a halt restarts the core immediately from IDLE.
- `next_pc` is used as given, 32 bits. Zero-extension of the 26-bit jump target is done upstream.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `pc`=`RESET_PC`, `ir`=0, `retired`=0, `fault`=0, halt pending=0, wait counter=0. All strobes are 0.
- Minimum cost is 4 cycles per instruction (FETCH, DECODE, EXEC, UPDATE) with zero-wait ack and immediate `exec_done`.
- `start` sampled high in IDLE at edge N gives FETCH, with `imem_req`=1, from cycle N+1.
- `pc` changes only on the clock edge that leaves UPDATE. `imem_addr` is stable for the whole FETCH stay.
- `ir` changes only on the FETCH→DECODE edge.
- All outputs are registered or decoded from the state register, with no combinational path from inputs.
- Reset asserted mid-FETCH or mid-EXEC aborts the operation. `retired` is not incremented.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum;
  - opcode constants (J=2, JAL=3, JR=1);
  - the instruction-type encoding (jump type=2).
- Sub-module `fetch_timeout_ctr`: an 8-bit wait counter with clear, enable and a terminal flag. It is instantiated once.
- `pc_increment` is instantiated by the core top-level, not inside this block.

## Test plan
- Reset with `RESET_PC`=0x10 → `pc`=0x10, `retired`=0, `fault`=0, `imem_req`=0, `running`=0.
- `start`=1, zero-wait ack, `exec_done` immediate, `next_pc`=`pc`+1 → `imem_addr` sequence 0x10, 0x11, 0x12 exactly 4 cycles apart. `retired`=3 after 12 cycles.
- Ack delayed 3 cycles → `imem_req` held 4 cycles, `imem_addr` constant, `ir`=`imem_rdata` of the ack cycle, single `ir_valid` pulse.
- Jump with `next_pc`=0x2A in UPDATE → next FETCH `imem_addr`=0x2A, `pc_commit` a single pulse.
- `halt_req` pulse during EXEC → UPDATE still commits (`retired`+1), then IDLE, `running`=0, `pc`=committed `next_pc`.
- No ack for 16 FETCH cycles → `fault`=1, `imem_req`=0, `start` ignored. Then `rst_n`=0 mid-FAULT → immediate return to reset values.
